// File: rtl/trng_multi_src.sv
// trng_multi_src
//   Entropy front-end. It XOR-folds NUM_SRC sampled noise bits into one bit per
//   valid sample. Von Neumann de-biasing is optional. Repetition-count and
//   adaptive-proportion health tests run on every folded bit. Conditioned bits
//   are packed MSB-first into WIDTH-bit words. After each enable, the first
//   STARTUP_WORDS words are discarded. Later words are buffered in a
//   first-word-fall-through FIFO behind a valid/ready port.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   enable               level, collect entropy while high
//   vn_en                Von Neumann mode, captured when leaving IDLE
//   noise_in             raw noise bits, one per source
//   noise_valid          noise_in carries a fresh sample this cycle
//   out_data             FIFO head word (zero while empty)
//   out_valid            FIFO non-empty
//   out_ready            consumer takes out_data when out_valid is high
//   fifo_level           words held in the FIFO
//   alarm, alarm_src     sticky health failure, cause bits [0]=RCT [1]=APT
//   alarm_clr            pulse, clears the alarm and releases ERROR to IDLE
//   busy                 collecting (STARTUP or RUN)
module trng_multi_src #(
  parameter int NUM_SRC       = 4,
  parameter int WIDTH         = 32,
  parameter int FIFO_DEPTH    = 16,
  parameter int RCT_CUTOFF    = 32,
  parameter int APT_WINDOW    = 512,
  parameter int APT_CUTOFF    = 400,
  parameter int STARTUP_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          enable,
  input  logic                          vn_en,
  input  logic [NUM_SRC-1:0]            noise_in,
  input  logic                          noise_valid,
  output logic [WIDTH-1:0]              out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          alarm,
  output logic [1:0]                    alarm_src,
  input  logic                          alarm_clr,
  output logic                          busy
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int BW   = $clog2(WIDTH);
  localparam int SW   = $clog2(STARTUP_WORDS + 2);
  localparam int RW   = $clog2(RCT_CUTOFF + 1);
  localparam int AMAX = (APT_CUTOFF > APT_WINDOW) ? APT_CUTOFF : APT_WINDOW;
  localparam int AW   = $clog2(AMAX + 1);

  localparam logic [PW:0]   LVL_FULL     = (PW+1)'(FIFO_DEPTH);
  localparam logic [BW-1:0] BIT_LAST     = BW'(WIDTH - 1);
  localparam logic [SW-1:0] SU_LAST      = SW'(STARTUP_WORDS - 1);
  localparam logic [RW-1:0] RCT_LIM      = RW'(RCT_CUTOFF);
  localparam logic [AW-1:0] APT_LIM      = AW'(APT_CUTOFF);
  localparam logic [AW-1:0] APT_IDX_LAST = AW'(APT_WINDOW - 1);

  typedef enum logic [1:0] {S_IDLE, S_STARTUP, S_RUN, S_ERROR} state_t;

  state_t            state;
  logic              vn_mode;
  logic              pair_phase;   // 1 = first bit of a VN pair is held
  logic              pair_first;
  logic [WIDTH-1:0]  sreg;
  logic [BW-1:0]     bit_cnt;
  logic [SW-1:0]     word_cnt;
  logic              rct_last;
  logic [RW-1:0]     rct_cnt;      // 0 = no sample seen since enable
  logic              apt_ref;
  logic [AW-1:0]     apt_cnt;
  logic [AW-1:0]     apt_idx;      // position inside the current window

  logic [WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;

  logic              fold;
  logic              sample;
  logic [RW-1:0]     rct_cnt_nxt;
  logic [AW-1:0]     apt_cnt_nxt;
  logic              rct_fail;
  logic              apt_fail;
  logic              fail;
  logic              cbit_vld;
  logic              take;
  logic              word_done;
  logic              pop;
  logic              push;

  always_comb begin
    fold        = ^noise_in;
    sample      = noise_valid && (state == S_STARTUP || state == S_RUN);
    rct_cnt_nxt = (rct_cnt != '0 && fold == rct_last) ? rct_cnt + RW'(1) : RW'(1);
    if (apt_idx == '0)
      apt_cnt_nxt = AW'(1);
    else if (fold == apt_ref)
      apt_cnt_nxt = apt_cnt + AW'(1);
    else
      apt_cnt_nxt = apt_cnt;
    rct_fail  = sample && (rct_cnt_nxt == RCT_LIM);
    apt_fail  = sample && (apt_cnt_nxt == APT_LIM);
    fail      = rct_fail || apt_fail;
    // VN: only a differing pair emits a bit, and that bit equals the second sample
    cbit_vld  = vn_mode ? (pair_phase && (pair_first != fold)) : 1'b1;
    // A failing sample, or one arriving as enable drops, never reaches the packer
    take      = sample && enable && !fail && cbit_vld;
    word_done = take && (bit_cnt == BIT_LAST);
    // The flush on a failure overrides any handshake in the same cycle
    pop       = out_valid && out_ready && !fail;
    push      = word_done && (state == S_RUN) && (fifo_level != LVL_FULL || pop);
  end

  assign out_valid = (fifo_level != '0);
  assign out_data  = out_valid ? mem[rptr] : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      alarm      <= 1'b0;
      alarm_src  <= 2'b00;
      vn_mode    <= 1'b0;
      pair_phase <= 1'b0;
      pair_first <= 1'b0;
      sreg       <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      rct_last   <= 1'b0;
      rct_cnt    <= '0;
      apt_ref    <= 1'b0;
      apt_cnt    <= '0;
      apt_idx    <= '0;
    end else begin
      if (alarm_clr) begin
        alarm     <= 1'b0;
        alarm_src <= 2'b00;
      end
      case (state)
        S_IDLE: begin
          if (enable) begin
            state      <= (STARTUP_WORDS == 0) ? S_RUN : S_STARTUP;
            busy       <= 1'b1;
            vn_mode    <= vn_en;
            pair_phase <= 1'b0;
            sreg       <= '0;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            rct_cnt    <= '0;
            apt_cnt    <= '0;
            apt_idx    <= '0;
          end
        end
        S_STARTUP, S_RUN: begin
          if (fail) begin
            // Placed after the alarm_clr clear so a failure always wins
            state     <= S_ERROR;
            busy      <= 1'b0;
            alarm     <= 1'b1;
            alarm_src <= alarm_src | {apt_fail, rct_fail};
          end else if (!enable) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (sample) begin
            rct_last   <= fold;
            rct_cnt    <= rct_cnt_nxt;
            apt_cnt    <= apt_cnt_nxt;
            if (apt_idx == '0)
              apt_ref <= fold;
            apt_idx    <= (apt_idx == APT_IDX_LAST) ? '0 : apt_idx + AW'(1);
            pair_phase <= ~pair_phase;
            pair_first <= fold;
            if (take) begin
              sreg    <= {sreg[WIDTH-2:0], fold};
              bit_cnt <= word_done ? '0 : bit_cnt + BW'(1);
            end
            if (word_done && state == S_STARTUP) begin
              word_cnt <= word_cnt + SW'(1);
              if (word_cnt == SU_LAST)
                state <= S_RUN;
            end
          end
        end
        S_ERROR: begin
          if (alarm_clr) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
    end else if (fail) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + (PW+1)'(1);
        2'b01:   fifo_level <= fifo_level - (PW+1)'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // The completed word bypasses sreg so it is written on the cycle its last bit arrives
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {sreg[WIDTH-2:0], fold};
  end

endmodule
